// File: rtl/rhd_seq_ctrl_pkg.sv
// Shared types and command encodings for the RHD ADC sequencer.
package rhd_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP  = 3'd0,
    ST_CFG    = 3'd1,
    ST_CAL    = 3'd2,
    ST_CALDMY = 3'd3,
    ST_READY  = 3'd4,
    ST_FRAME  = 3'd5
  } main_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_ISSUE = 2'd1,
    TX_GAP   = 2'd2
  } tx_state_t;

  localparam logic [1:0]  OP_CONVERT    = 2'b00;
  localparam logic [1:0]  OP_WRITE      = 2'b10;
  localparam logic [1:0]  OP_READ       = 2'b11;
  localparam logic [5:0]  REG_DUMMY     = 6'h3F;
  localparam logic [15:0] CMD_CALIBRATE = 16'h5500;
  localparam logic [15:0] CMD_DUMMY     = {OP_READ, REG_DUMMY, 8'h00};

  function automatic logic [15:0] cmd_convert(input logic [5:0] ch);
    return {OP_CONVERT, ch, 8'h00};
  endfunction

  function automatic logic [15:0] cmd_write(input logic [13:0] reg_val);
    return {OP_WRITE, reg_val};
  endfunction

endpackage

// File: rtl/rhd_seq_ctrl_if.sv
// SPI master handshake between the sequencer and the SPI shift engine.
interface rhd_seq_ctrl_if;
  logic        fs;
  logic        fd;
  logic        prd;
  logic [15:0] txd;
  logic [15:0] rxd0;
  logic [15:0] rxd1;

  modport master (output fs, txd, input fd, prd, rxd0, rxd1);
  modport slave  (input fs, txd, output fd, prd, rxd0, rxd1);
endinterface

// File: rtl/rhd_seq_ctrl_cfg_rom.sv
// Power-up register configuration ROM: idx -> {reg[5:0], val[7:0]}.
module rhd_seq_ctrl_cfg_rom
  import rhd_seq_ctrl_pkg::*;
#(
  parameter int NUM_CFG = 18
) (
  input  logic [6:0]  idx,
  output logic [13:0] word
);

  logic [7:0] val_s;

  // Register value table; the register address is the table index.
  always_comb begin
    val_s = 8'h00;
    case (idx)
      7'd0:    val_s = 8'hDE;
      7'd1:    val_s = 8'h02;
      7'd2:    val_s = 8'h04;
      7'd3:    val_s = 8'h00;
      7'd4:    val_s = 8'h16;
      7'd5:    val_s = 8'h00;
      7'd6:    val_s = 8'h00;
      7'd7:    val_s = 8'h00;
      7'd8:    val_s = 8'h16;
      7'd9:    val_s = 8'h17;
      7'd10:   val_s = 8'hA8;
      7'd11:   val_s = 8'h00;
      7'd12:   val_s = 8'h10;
      7'd13:   val_s = 8'h7C;
      7'd14:   val_s = 8'hFF;
      7'd15:   val_s = 8'hFF;
      7'd16:   val_s = 8'hFF;
      7'd17:   val_s = 8'hFF;
      default: val_s = 8'h00;
    endcase
  end

  // Entries beyond the configured depth read as zero.
  always_comb begin
    if (idx < 7'(NUM_CFG)) begin
      word = {idx[5:0], val_s};
    end else begin
      word = 14'h0000;
    end
  end

endmodule

// File: rtl/rhd_seq_ctrl.sv
// RHD ADC sequencer: power-up, config, calibration, then per-tick CONVERT frames
// with 2-deep SPI pipeline re-tagging of returned samples.
module rhd_seq_ctrl
  import rhd_seq_ctrl_pkg::*;
#(
  parameter int NUM_CH    = 32,
  parameter int PWRUP_CYC = 1000,
  parameter int NUM_CFG   = 18,
  parameter int CAL_DUMMY = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  sample_tick,
  rhd_seq_ctrl_if.master        spi,
  output logic                  smp_valid,
  output logic [5:0]            smp_chan,
  output logic [31:0]           smp_data,
  output logic                  init_done,
  output logic                  busy,
  output logic                  overrun
);

  localparam int              PW         = $clog2(PWRUP_CYC + 1);
  localparam logic [PW-1:0]   PWRUP_LAST = PW'(PWRUP_CYC - 1);
  localparam logic [6:0]      N_CFG      = 7'(NUM_CFG);
  localparam logic [6:0]      N_DMY      = 7'(CAL_DUMMY);
  localparam logic [6:0]      N_CH       = 7'(NUM_CH);
  localparam logic [6:0]      N_FRM      = 7'(NUM_CH + 2);

  main_state_t   state_r, state_s, state_after_s;
  tx_state_t     tx_r, tx_s;
  logic [PW-1:0] pwr_cnt_r, pwr_cnt_s;
  logic [6:0]    cmd_cnt_r, cmd_cnt_s, cmd_total_s;
  logic [15:0]   cmd_word_s;
  logic [13:0]   rom_word_s;
  logic          fs_r, fs_s;
  logic [15:0]   txd_r, txd_s;
  logic          smp_valid_r, smp_valid_s;
  logic [5:0]    smp_chan_r, smp_chan_s;
  logic [31:0]   smp_data_r, smp_data_s;
  logic          init_done_r, init_done_s;
  logic          busy_r, busy_s;
  logic          overrun_r, overrun_s;

  rhd_seq_ctrl_cfg_rom #(.NUM_CFG(NUM_CFG)) u_cfg_rom (
    .idx  (cmd_cnt_r),
    .word (rom_word_s)
  );

  // Per-state command count, successor state and current command word.
  always_comb begin
    cmd_total_s   = 7'd0;
    state_after_s = ST_READY;
    cmd_word_s    = 16'h0000;
    case (state_r)
      ST_CFG: begin
        cmd_total_s   = N_CFG;
        state_after_s = ST_CAL;
        cmd_word_s    = cmd_write(rom_word_s);
      end
      ST_CAL: begin
        cmd_total_s   = 7'd1;
        state_after_s = ST_CALDMY;
        cmd_word_s    = CMD_CALIBRATE;
      end
      ST_CALDMY: begin
        cmd_total_s   = N_DMY;
        state_after_s = ST_READY;
        cmd_word_s    = CMD_DUMMY;
      end
      ST_FRAME: begin
        cmd_total_s   = N_FRM;
        state_after_s = ST_READY;
        if (cmd_cnt_r < N_CH) begin
          cmd_word_s = cmd_convert(cmd_cnt_r[5:0]);
        end else begin
          cmd_word_s = CMD_DUMMY;
        end
      end
      default: begin
        cmd_total_s   = 7'd0;
        state_after_s = ST_READY;
        cmd_word_s    = 16'h0000;
      end
    endcase
  end

  // Main sequencer and transaction engine next-state logic.
  always_comb begin
    state_s     = state_r;
    tx_s        = tx_r;
    pwr_cnt_s   = pwr_cnt_r;
    cmd_cnt_s   = cmd_cnt_r;
    fs_s        = fs_r;
    txd_s       = txd_r;
    smp_valid_s = 1'b0;
    smp_chan_s  = smp_chan_r;
    smp_data_s  = smp_data_r;
    init_done_s = init_done_r;
    overrun_s   = overrun_r | (sample_tick & (state_r != ST_READY));

    case (state_r)
      ST_PWRUP: begin
        if (pwr_cnt_r == PWRUP_LAST) begin
          state_s   = ST_CFG;
          cmd_cnt_s = 7'd0;
        end else begin
          pwr_cnt_s = pwr_cnt_r + PW'(1);
        end
      end
      ST_READY: begin
        if (sample_tick && enable) begin
          state_s   = ST_FRAME;
          cmd_cnt_s = 7'd0;
        end else begin
          state_s = ST_READY;
        end
      end
      ST_CFG, ST_CAL, ST_CALDMY, ST_FRAME: begin
        case (tx_r)
          TX_IDLE: begin
            // Advancing from idle lets a zero-length command state pass straight through.
            if (cmd_cnt_r == cmd_total_s) begin
              state_s   = state_after_s;
              cmd_cnt_s = 7'd0;
              if (state_r == ST_CALDMY) begin
                init_done_s = 1'b1;
              end else begin
                init_done_s = init_done_r;
              end
            end else begin
              fs_s  = 1'b1;
              txd_s = cmd_word_s;
              tx_s  = TX_ISSUE;
            end
          end
          TX_ISSUE: begin
            if (spi.fd) begin
              fs_s      = 1'b0;
              tx_s      = TX_GAP;
              cmd_cnt_s = cmd_cnt_r + 7'd1;
              if (state_r == ST_FRAME && cmd_cnt_r >= 7'd2) begin
                smp_valid_s = 1'b1;
                smp_chan_s  = 6'(cmd_cnt_r - 7'd2);
                smp_data_s  = {spi.rxd1, spi.rxd0};
              end else begin
                smp_valid_s = 1'b0;
              end
            end else begin
              fs_s = 1'b1;
            end
          end
          TX_GAP: begin
            if (spi.prd) begin
              tx_s = TX_IDLE;
            end else begin
              tx_s = TX_GAP;
            end
          end
          default: tx_s = TX_IDLE;
        endcase
      end
      default: state_s = ST_PWRUP;
    endcase

    busy_s = (state_s != ST_READY);
  end

  // State and output registers; reset drops fs immediately and restarts at power-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_PWRUP;
      tx_r        <= TX_IDLE;
      pwr_cnt_r   <= '0;
      cmd_cnt_r   <= 7'd0;
      fs_r        <= 1'b0;
      txd_r       <= 16'h0000;
      smp_valid_r <= 1'b0;
      smp_chan_r  <= 6'd0;
      smp_data_r  <= 32'h0000_0000;
      init_done_r <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      tx_r        <= tx_s;
      pwr_cnt_r   <= pwr_cnt_s;
      cmd_cnt_r   <= cmd_cnt_s;
      fs_r        <= fs_s;
      txd_r       <= txd_s;
      smp_valid_r <= smp_valid_s;
      smp_chan_r  <= smp_chan_s;
      smp_data_r  <= smp_data_s;
      init_done_r <= init_done_s;
      busy_r      <= busy_s;
      overrun_r   <= overrun_s;
    end
  end

  assign spi.fs    = fs_r;
  assign spi.txd   = txd_r;
  assign smp_valid = smp_valid_r;
  assign smp_chan  = smp_chan_r;
  assign smp_data  = smp_data_r;
  assign init_done = init_done_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_rhd_seq_ctrl.sv
// Directed scoreboard bench for rhd_seq_ctrl with a pipelined SPI master model.
module tb_rhd_seq_ctrl;

  localparam int NUM_CH    = 4;
  localparam int PWRUP_CYC = 10;
  localparam int NUM_CFG   = 18;
  localparam int CAL_DUMMY = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        sample_tick = 1'b0;
  logic        smp_valid;
  logic [5:0]  smp_chan;
  logic [31:0] smp_data;
  logic        init_done;
  logic        busy;
  logic        overrun;

  rhd_seq_ctrl_if spi_if ();

  rhd_seq_ctrl #(
    .NUM_CH(NUM_CH), .PWRUP_CYC(PWRUP_CYC), .NUM_CFG(NUM_CFG), .CAL_DUMMY(CAL_DUMMY)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_tick(sample_tick), .spi(spi_if),
    .smp_valid(smp_valid), .smp_chan(smp_chan), .smp_data(smp_data),
    .init_done(init_done), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // SPI master model: fd 20 cycles after fs, prd 4 after fd; MISO carries command i-2.
  logic [1:0]  m_phase = 2'd0;
  logic [4:0]  m_cnt = 5'd0;
  logic [15:0] hist0 = 16'h0000, hist1 = 16'h0000;
  initial begin
    spi_if.fd = 1'b0; spi_if.prd = 1'b0; spi_if.rxd0 = 16'h0000; spi_if.rxd1 = 16'h0000;
  end
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 2'd0; m_cnt <= 5'd0; hist0 <= 16'h0000; hist1 <= 16'h0000;
      spi_if.fd <= 1'b0; spi_if.prd <= 1'b0;
    end else begin
      case (m_phase)
        2'd0: if (spi_if.fs) begin
          spi_if.rxd0 <= hist1;
          spi_if.rxd1 <= hist1 ^ 16'hA5A5;
          hist1 <= hist0; hist0 <= spi_if.txd;
          m_cnt <= 5'd1; m_phase <= 2'd1;
        end
        2'd1: if (m_cnt == 5'd19) begin
          spi_if.fd <= 1'b1; m_cnt <= 5'd0; m_phase <= 2'd2;
        end else m_cnt <= m_cnt + 5'd1;
        2'd2: begin
          spi_if.fd <= 1'b0;
          if (m_cnt == 5'd3) begin spi_if.prd <= 1'b1; m_phase <= 2'd3; end
          else m_cnt <= m_cnt + 5'd1;
        end
        default: begin spi_if.prd <= 1'b0; m_phase <= 2'd0; end
      endcase
    end
  end

  // Observation capture: command words at fs rise, txd stability, sample strobes.
  logic [15:0] obs_cmd [0:255];
  logic [37:0] obs_smp [0:255];
  int          obs_cmd_n = 0, obs_smp_n = 0, stab_err = 0;
  logic        fs_q = 1'b0;
  logic [15:0] txd_q = 16'h0000;
  always @(negedge clk) begin
    if (spi_if.fs === 1'b1 && !fs_q && obs_cmd_n < 256) begin
      obs_cmd[obs_cmd_n] <= spi_if.txd; obs_cmd_n <= obs_cmd_n + 1;
    end
    if (spi_if.fs === 1'b1 && fs_q && spi_if.txd !== txd_q) stab_err <= stab_err + 1;
    fs_q <= (spi_if.fs === 1'b1); txd_q <= spi_if.txd;
    if (smp_valid === 1'b1 && obs_smp_n < 256) begin
      obs_smp[obs_smp_n] <= {smp_chan, smp_data}; obs_smp_n <= obs_smp_n + 1;
    end
  end

  int          tests_run = 0, tests_failed = 0;
  int          cmd_rd = 0, smp_rd = 0;
  logic [15:0] exp_cmd_q [$];
  logic [37:0] exp_smp_q [$];
  logic [7:0]  cfg_val [0:17] = '{8'hDE, 8'h02, 8'h04, 8'h00, 8'h16, 8'h00, 8'h00, 8'h00, 8'h16,
                                  8'h17, 8'hA8, 8'h00, 8'h10, 8'h7C, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_init();
    for (int i = 0; i < NUM_CFG; i++) exp_cmd_q.push_back({2'b10, 6'(i), cfg_val[i]});
    exp_cmd_q.push_back(16'h5500);
    for (int i = 0; i < CAL_DUMMY; i++) exp_cmd_q.push_back(16'hFF00);
  endtask

  task automatic push_frame();
    logic [15:0] c;
    for (int i = 0; i < NUM_CH + 2; i++) begin
      c = (i < NUM_CH) ? {2'b00, 6'(i), 8'h00} : 16'hFF00;
      exp_cmd_q.push_back(c);
      if (i < NUM_CH) exp_smp_q.push_back({6'(i), c ^ 16'hA5A5, c});
    end
  endtask

  task automatic drain(input string tag);
    logic [15:0] ec; logic [37:0] es;
    int i = 0;
    while (exp_cmd_q.size() > 0) begin
      ec = exp_cmd_q.pop_front();
      chk($sformatf("%s_cmd%0d", tag, i), (cmd_rd < obs_cmd_n) ? 64'(obs_cmd[cmd_rd]) : 64'hx, 64'(ec));
      cmd_rd++; i++;
    end
    chk({tag, "_extra_cmds"}, 64'(obs_cmd_n > cmd_rd ? obs_cmd_n - cmd_rd : 0), 64'd0);
    cmd_rd = obs_cmd_n; i = 0;
    while (exp_smp_q.size() > 0) begin
      es = exp_smp_q.pop_front();
      chk($sformatf("%s_smp%0d", tag, i), (smp_rd < obs_smp_n) ? 64'(obs_smp[smp_rd]) : 64'hx, 64'(es));
      smp_rd++; i++;
    end
    chk({tag, "_extra_smps"}, 64'(obs_smp_n > smp_rd ? obs_smp_n - smp_rd : 0), 64'd0);
    smp_rd = obs_smp_n;
  endtask

  task automatic wait_busy(input logic val, input int bound, input string tag);
    int n = 0;
    while (busy !== val && n < bound) begin @(negedge clk); n++; end
    chk({tag, "_busy_wait"}, 64'(busy), 64'(val));
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (init_done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk({tag, "_init_done"}, 64'(init_done), 64'd1);
    chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
    drain(tag);
  endtask

  task automatic pulse_tick();
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
  endtask

  initial begin
    int cyc;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fs_txd", {47'd0, spi_if.fs, spi_if.txd}, 64'd0);
    chk("rst_smp", {25'd0, smp_valid, smp_chan, smp_data}, 64'd0);
    chk("rst_status", {61'd0, init_done, busy, overrun}, 64'd0);

    // 1: power-up wait then first config write
    push_init();
    @(negedge clk); rst = 1'b0;
    cyc = 0;
    while (spi_if.fs !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    tests_run++;
    assert (cyc >= PWRUP_CYC - 1 && cyc <= PWRUP_CYC + 1) else begin
      tests_failed++;
      $error("FAIL pwrup_first_fs: observed cycle %0d expected %0d..%0d", cyc, PWRUP_CYC - 1, PWRUP_CYC + 1);
    end
    chk("first_txd", 64'(spi_if.txd), 64'h80DE);

    // 2: full init sequence
    wait_init("init");

    // 3: one frame
    enable = 1'b1;
    push_frame();
    pulse_tick();
    chk("frame_busy", 64'(busy), 64'd1);
    wait_busy(1'b0, 1000, "frame1");
    drain("frame1");
    chk("frame1_overrun", 64'(overrun), 64'd0);

    // 6: enable drop mid-frame finishes the frame, then ticks are ignored
    push_frame();
    pulse_tick();
    repeat (30) @(negedge clk);
    enable = 1'b0;
    wait_busy(1'b0, 1000, "endrop");
    drain("endrop");
    for (int k = 0; k < 3; k++) begin pulse_tick(); repeat (20) @(negedge clk); end
    chk("disabled_busy", 64'(busy), 64'd0);
    chk("disabled_overrun", 64'(overrun), 64'd0);
    drain("disabled");

    // 4: tick mid-frame sets overrun, frame unaffected; next tick runs normally
    enable = 1'b1;
    push_frame();
    pulse_tick();
    repeat (30) @(negedge clk);
    pulse_tick();
    chk("overrun_set", 64'(overrun), 64'd1);
    wait_busy(1'b0, 1000, "ovr");
    drain("ovr");
    push_frame();
    pulse_tick();
    wait_busy(1'b1, 10, "after_ovr");
    wait_busy(1'b0, 1000, "after_ovr");
    drain("after_ovr");
    chk("overrun_sticky", 64'(overrun), 64'd1);

    // 5: reset mid-transaction kills fs at once and re-runs init
    pulse_tick();
    cyc = 0;
    while (spi_if.fs !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_kills_fs", 64'(spi_if.fs), 64'd0);
    chk("rst_clears", {61'd0, init_done, busy, overrun}, 64'd0);
    exp_cmd_q.delete(); exp_smp_q.delete();
    repeat (3) @(negedge clk);
    cmd_rd = obs_cmd_n; smp_rd = obs_smp_n;
    push_init();
    rst = 1'b0;
    wait_init("reinit");

    chk("txd_stable", 64'(stab_err), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
